// File: rtl/conv3x3_mc_featuremap_if.sv
// conv3x3_mc_featuremap_if
// Groups the pixel stream, the weight-bank load/commit port and the result
// stream of conv3x3_mc_featuremap into one bundle.
//   master : drives data_in/valid_in and w_load/w_addr/w_data/w_commit,
//            observes commit_pending/data_out/valid_out
//   slave  : the convolution block itself
// DATA_WIDTH and CH_IN must match the parameters of the attached block.
interface conv3x3_mc_featuremap_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_IN      = 3
);
  localparam int AW = $clog2(CH_IN * 9 + 1);

  logic [CH_IN*DATA_WIDTH-1:0] data_in;
  logic                        valid_in;
  logic                        w_load;
  logic [AW-1:0]               w_addr;
  logic [DATA_WIDTH-1:0]       w_data;
  logic                        w_commit;
  logic                        commit_pending;
  logic [DATA_WIDTH-1:0]       data_out;
  logic                        valid_out;

  modport master (
    output data_in, valid_in, w_load, w_addr, w_data, w_commit,
    input  commit_pending, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, w_load, w_addr, w_data, w_commit,
    output commit_pending, data_out, valid_out
  );
endinterface

// File: rtl/conv3x3_mc_featuremap.sv
// conv3x3_mc_featuremap
// Multi-channel 3x3 valid convolution producing one output feature map.
// CH_IN channels arrive together, one pixel per valid_in, in raster order.
// Each channel keeps two line buffers and a 3x3 window; all CH_IN*9
// products plus bias are summed, rounded and saturated in a 3-cycle pipe.
// Weights/bias live in a shadow bank (written by w_load) that is copied to
// the active bank on w_commit, either at once when the frame is idle or
// deferred to the edge accepting the frame's last pixel.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : conv3x3_mc_featuremap_if.slave (stream, weight port, result)
// Optional macro LEAKY_RELU_EN: negative results become x >>> 3.
module conv3x3_mc_featuremap #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CH_IN      = 3,
  parameter int IMG_SIZE   = 416,
  parameter int ACC_WIDTH  = 40
) (
  input logic                    Clk,
  input logic                    Rst,
  conv3x3_mc_featuremap_if.slave bus
);
  localparam int NW = CH_IN * 9;
  localparam int AW = $clog2(NW + 1);
  localparam int CW = $clog2(IMG_SIZE);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [CW-1:0] col, row;
  logic          frame_idle, last_pix, do_copy, win_ok;
  logic          commit_pending;

  logic signed [DATA_WIDTH-1:0] shadow      [NW+1];
  logic signed [DATA_WIDTH-1:0] shadow_next [NW+1];
  logic signed [DATA_WIDTH-1:0] active      [NW+1];

  logic signed [DATA_WIDTH-1:0] lb0 [CH_IN][IMG_SIZE];
  logic signed [DATA_WIDTH-1:0] lb1 [CH_IN][IMG_SIZE];
  logic signed [DATA_WIDTH-1:0] win [CH_IN][3][2];
  logic signed [DATA_WIDTH-1:0] tap [CH_IN][3];
  logic signed [DATA_WIDTH-1:0] pix [NW];

  logic signed [PW-1:0]         prod_s1 [NW];
  logic signed [DATA_WIDTH-1:0] bias_s1;
  logic signed [ACC_WIDTH-1:0]  sum_c, acc_s2, shr_s3;
  logic signed [DATA_WIDTH-1:0] sat_c, act_c;
  logic                         v_s1, v_s2, v_s3;
  logic signed [DATA_WIDTH-1:0] data_out_r;
  logic                         valid_out_r;

  assign frame_idle = (row == '0) && (col == '0);
  assign last_pix   = bus.valid_in && (row == LAST) && (col == LAST);
  assign win_ok     = bus.valid_in && (row >= CW'(2)) && (col >= CW'(2));
  // The last pixel's products are registered from the old active bank on
  // the same edge that performs the deferred copy, so that window is safe.
  assign do_copy    = (bus.w_commit && frame_idle) ||
                      ((commit_pending || bus.w_commit) && last_pix);

  assign bus.commit_pending = commit_pending;
  assign bus.data_out       = data_out_r;
  assign bus.valid_out      = valid_out_r;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Column taps: lb1 holds row r-2, lb0 row r-1, the live pixel is row r.
  // pix flattens the full window as c*9 + ky*3 + kx, kx=2 being newest.
  always_comb begin
    for (int c = 0; c < CH_IN; c++) begin
      tap[c][0] = lb1[c][col];
      tap[c][1] = lb0[c][col];
      tap[c][2] = bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
      for (int ky = 0; ky < 3; ky++) begin
        pix[c*9 + ky*3 + 0] = win[c][ky][0];
        pix[c*9 + ky*3 + 1] = win[c][ky][1];
        pix[c*9 + ky*3 + 2] = tap[c][ky];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (bus.valid_in) begin
      for (int c = 0; c < CH_IN; c++) begin
        lb1[c][col] <= lb0[c][col];
        lb0[c][col] <= tap[c][2];
        for (int ky = 0; ky < 3; ky++) begin
          win[c][ky][0] <= win[c][ky][1];
          win[c][ky][1] <= tap[c][ky];
        end
      end
    end
  end

  // A write in the same cycle as a copy must land in the active bank too.
  always_comb begin
    for (int i = 0; i <= NW; i++) shadow_next[i] = shadow[i];
    if (bus.w_load && (bus.w_addr <= AW'(NW))) shadow_next[bus.w_addr] = bus.w_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i <= NW; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i <= NW; i++) shadow[i] <= shadow_next[i];
      if (do_copy) begin
        for (int i = 0; i <= NW; i++) active[i] <= shadow_next[i];
        commit_pending <= 1'b0;
      end else if (bus.w_commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Bias travels with its products so a commit on the last pixel cannot
  // alter the bias of windows already in the pipe.
  always_comb begin
    sum_c = (ACC_WIDTH'(bias_s1) <<< FRAC_BITS) + HALF;
    for (int i = 0; i < NW; i++) sum_c = sum_c + ACC_WIDTH'(prod_s1[i]);
  end

  always_comb begin
    if (shr_s3 > ACC_MAX)      sat_c = OUT_MAX;
    else if (shr_s3 < ACC_MIN) sat_c = OUT_MIN;
    else                       sat_c = shr_s3[DATA_WIDTH-1:0];
`ifdef LEAKY_RELU_EN
    act_c = sat_c[DATA_WIDTH-1] ? (sat_c >>> 3) : sat_c;
`else
    act_c = sat_c;
`endif
  end

  always_ff @(posedge Clk) begin
    if (win_ok) begin
      for (int i = 0; i < NW; i++) prod_s1[i] <= PW'(pix[i]) * PW'(active[i]);
      bias_s1 <= active[NW];
    end
    if (v_s1) acc_s2 <= sum_c;
    if (v_s2) shr_s3 <= acc_s2 >>> FRAC_BITS;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      v_s1        <= 1'b0;
      v_s2        <= 1'b0;
      v_s3        <= 1'b0;
      valid_out_r <= 1'b0;
      data_out_r  <= '0;
    end else begin
      v_s1        <= win_ok;
      v_s2        <= v_s1;
      v_s3        <= v_s2;
      valid_out_r <= v_s3;
      if (v_s3) data_out_r <= act_c;
    end
  end
endmodule

// File: tb/tb_conv3x3_mc_featuremap.sv
// tb_conv3x3_mc_featuremap
// Directed and randomized checks of conv3x3_mc_featuremap on a 4x4, 3-channel
// configuration. Expected pixels come from fixed constants or from a
// frame-level convolution model; a scoreboard queue holds each expected
// result with the clock edge on which it must appear.
module tb_conv3x3_mc_featuremap;
  localparam int DW   = 16;
  localparam int FB   = 8;
  localparam int CH   = 3;
  localparam int IMG  = 4;
  localparam int NW   = CH * 9;
  localparam int AW   = $clog2(NW + 1);
  localparam int NPIX = IMG * IMG;

  typedef struct {
    int          due;
    logic [DW-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  logic [DW-1:0] m_shadow [NW+1];
  logic [DW-1:0] m_active [NW+1];
  bit            m_pending;
  logic [DW-1:0] px [CH][NPIX];
  exp_t          exp_q [$];

  conv3x3_mc_featuremap_if #(.DATA_WIDTH(DW), .CH_IN(CH)) bus ();

  conv3x3_mc_featuremap #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .CH_IN(CH), .IMG_SIZE(IMG), .ACC_WIDTH(40)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, want, cyc);
  endtask

  // Every edge either owes exactly the head of the scoreboard or nothing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check_output("valid_out", DW'(bus.valid_out), DW'(1));
        check_output("data_out", bus.data_out, exp_q[0].val);
        void'(exp_q.pop_front());
      end else begin
        check_output("idle_valid_out", DW'(bus.valid_out), DW'(0));
      end
    end
  end

  function automatic logic [DW-1:0] conv_out(input int r, input int c);
    longint s = 0;
    for (int ch = 0; ch < CH; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          s += longint'($signed(px[ch][(r-2+ky)*IMG + (c-2+kx)])) *
               longint'($signed(m_active[ch*9 + ky*3 + kx]));
    s += longint'($signed(m_active[NW])) * 256;
    s += 128;
    s = s >>> FB;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef LEAKY_RELU_EN
    if (s < 0) s = s >>> 3;
`endif
    return DW'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NW; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_weights(input logic [DW-1:0] w[NW+1]);
    for (int a = 0; a <= NW; a++) begin
      bus.w_load = 1'b1;
      bus.w_addr = AW'(a);
      bus.w_data = w[a];
      @(negedge clk);
      m_shadow[a] = w[a];
    end
    bus.w_load = 1'b0;
  endtask

  task automatic write_one(input int addr, input logic [DW-1:0] d);
    bus.w_load = 1'b1;
    bus.w_addr = AW'(addr);
    bus.w_data = d;
    @(negedge clk);
    bus.w_load = 1'b0;
    if (addr <= NW) m_shadow[addr] = d;
  endtask

  task automatic commit_idle(input bit with_load, input int addr, input logic [DW-1:0] d);
    bus.w_commit = 1'b1;
    bus.w_load   = with_load;
    bus.w_addr   = AW'(addr);
    bus.w_data   = d;
    @(negedge clk);
    bus.w_commit = 1'b0;
    bus.w_load   = 1'b0;
    if (with_load && addr <= NW) m_shadow[addr] = d;
    for (int i = 0; i <= NW; i++) m_active[i] = m_shadow[i];
    m_pending = 1'b0;
    check_output("idle_commit_pending", DW'(bus.commit_pending), DW'(0));
  endtask

  task automatic apply_stimulus(input int gap_mode, input int commit_at, input int reset_at,
                                input bit use_fixed, input logic [DW-1:0] fx[4]);
    int k = 0;
    for (int i = 0; i < NPIX; i++) begin
      int r = i / IMG;
      int c = i % IMG;
      int n;
      bus.data_in  = {px[2][i], px[1][i], px[0][i]};
      bus.valid_in = 1'b1;
      if (i == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        model_reset();
        check_output("abort_data_out", bus.data_out, DW'(0));
        check_output("abort_commit_pending", DW'(bus.commit_pending), DW'(0));
        return;
      end
      if (r >= 2 && c >= 2) begin
        exp_t e;
        e.due = cyc + 4;
        e.val = use_fixed ? fx[k] : conv_out(r, c);
        exp_q.push_back(e);
        k++;
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (i == NPIX - 1 && m_pending) begin
        for (int a = 0; a <= NW; a++) m_active[a] = m_shadow[a];
        m_pending = 1'b0;
      end
      check_output("commit_pending", DW'(bus.commit_pending), DW'(m_pending));
      if (i == commit_at) begin
        int addr = $urandom_range(0, NW);
        logic [DW-1:0] d = DW'($urandom_range(0, 511)) - DW'(256);
        bus.w_commit = 1'b1;
        bus.w_load   = (gap_mode == 2);
        bus.w_addr   = AW'(addr);
        bus.w_data   = d;
        @(negedge clk);
        bus.w_commit = 1'b0;
        bus.w_load   = 1'b0;
        if (gap_mode == 2) m_shadow[addr] = d;
        m_pending = 1'b1;
        check_output("deferred_commit_pending", DW'(bus.commit_pending), DW'(1));
      end
      n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (n) @(negedge clk);
    end
  endtask

  initial begin
    logic [DW-1:0] w [NW+1];
    logic [DW-1:0] fx [4];
    logic [DW-1:0] zero4 [4];

    zero4 = '{default: '0};
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.w_load   = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    bus.w_commit = 1'b0;

    // 1: reset state, then a frame against the all-zero banks
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_valid_out", DW'(bus.valid_out), DW'(0));
    check_output("rst_data_out", bus.data_out, DW'(0));
    check_output("rst_commit_pending", DW'(bus.commit_pending), DW'(0));
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = DW'($urandom);
    apply_stimulus(0, -1, -1, 1'b1, zero4);
    $display("[TB] zero-weight frame streamed");

    // 2: identity on ch0 centre tap
    for (int a = 0; a <= NW; a++) w[a] = '0;
    w[4] = 16'h0100;
    load_weights(w);
    commit_idle(1'b0, 0, '0);
    for (int i = 0; i < NPIX; i++) begin
      px[0][i] = DW'(i * 256);
      px[1][i] = DW'($urandom);
      px[2][i] = DW'($urandom);
    end
    fx = '{16'h0500, 16'h0600, 16'h0900, 16'h0A00};
    apply_stimulus(0, -1, -1, 1'b1, fx);

    // 5: same frame with valid_in every other cycle
    apply_stimulus(1, -1, -1, 1'b1, fx);
    $display("[TB] identity frames streamed");

    // 3: all 27 weights 1.0, bias 0.5, pixels 1.0
    for (int a = 0; a < NW; a++) w[a] = 16'h0100;
    w[NW] = 16'h0080;
    load_weights(w);
    commit_idle(1'b0, 0, '0);
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = 16'h0100;
    fx = '{default: 16'h1B80};
    apply_stimulus(0, -1, -1, 1'b1, fx);

    // 4: saturation both ways
    for (int a = 0; a <= NW; a++) w[a] = 16'h7FFF;
    load_weights(w);
    commit_idle(1'b0, 0, '0);
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = 16'h7FFF;
    fx = '{default: 16'h7FFF};
    apply_stimulus(0, -1, -1, 1'b1, fx);
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = 16'h8001;
`ifdef LEAKY_RELU_EN
    fx = '{default: 16'hF000};
`else
    fx = '{default: 16'h8000};
`endif
    apply_stimulus(0, -1, -1, 1'b1, fx);
    $display("[TB] sum and saturation frames streamed");

    // 6: deferred commit; old set identity, new set 27 x 1.0
    for (int a = 0; a <= NW; a++) w[a] = '0;
    w[4] = 16'h0100;
    load_weights(w);
    commit_idle(1'b0, 0, '0);
    for (int a = 0; a < NW; a++) w[a] = 16'h0100;
    w[NW] = '0;
    load_weights(w);
    for (int i = 0; i < NPIX; i++) begin
      px[0][i] = DW'(i * 256);
      px[1][i] = DW'($urandom);
      px[2][i] = DW'($urandom);
    end
    fx = '{16'h0500, 16'h0600, 16'h0900, 16'h0A00};
    apply_stimulus(0, 6, -1, 1'b1, fx);
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = 16'h0100;
    fx = '{default: 16'h1B00};
    apply_stimulus(0, -1, -1, 1'b1, fx);
    apply_stimulus(0, -1, 12, 1'b1, fx);
    repeat (6) @(negedge clk);
    // Both banks must read back as zero: active without a commit, then shadow after one.
    for (int i = 0; i < NPIX; i++)
      for (int c = 0; c < CH; c++) px[c][i] = DW'($urandom);
    apply_stimulus(0, -1, -1, 1'b1, zero4);
    commit_idle(1'b0, 0, '0);
    apply_stimulus(2, -1, -1, 1'b1, zero4);
    $display("[TB] deferred commit and abort done");

    // Randomized frames against the convolution model
    for (int f = 0; f < 4; f++) begin
      if (f == 0) begin
        for (int a = 0; a <= NW; a++) w[a] = DW'($urandom_range(0, 511)) - DW'(256);
        load_weights(w);
        write_one(29 + int'($urandom_range(0, 2)), DW'($urandom));
        commit_idle(1'b1, $urandom_range(0, NW), DW'($urandom_range(0, 511)) - DW'(256));
      end else if (f == 3) begin
        for (int a = 0; a <= NW; a++) w[a] = DW'($urandom);
        load_weights(w);
        commit_idle(1'b0, 0, '0);
      end
      for (int i = 0; i < NPIX; i++)
        for (int c = 0; c < CH; c++)
          px[c][i] = (f == 3) ? DW'($urandom) : DW'($urandom_range(0, 2047)) - DW'(1024);
      apply_stimulus(2, (f == 1) ? int'($urandom_range(1, 13)) : -1, -1, 1'b0, zero4);
    end

    repeat (8) @(negedge clk);
    check_output("drain_empty", DW'(exp_q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
